// File: rtl/branch_resolve_unit.sv
// Decode-stage resolver for MIPS conditional branches: waits for forwarded operands,
// then issues a registered one-cycle taken/target pulse for PC redirect and IF flush.
module branch_resolve_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned MAX_WAIT   = 7,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  branchValid,
    input  logic [2:0]            branchOp,
    input  logic [DATA_WIDTH-1:0] dataRsInput,
    input  logic [DATA_WIDTH-1:0] dataRtInput,
    input  logic                  rsReady,
    input  logic                  rtReady,
    input  logic [PC_WIDTH-1:0]   pcPlus4Input,
    input  logic [15:0]           offsetInput,
    input  logic                  flush,
    output logic                  stallOutput,
    output logic                  resolvedValid,
    output logic                  takenOutput,
    output logic [PC_WIDTH-1:0]   targetOutput,
    output logic                  timeoutError,
    output logic [CNT_WIDTH-1:0]  stallCycles
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 2);

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLEZ = 3'b010;
    localparam logic [2:0] OP_BGTZ = 3'b011;
    localparam logic [2:0] OP_BLTZ = 3'b100;
    localparam logic [2:0] OP_BGEZ = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t              state, state_next;
    logic [2:0]          op_q;
    logic [PC_WIDTH-1:0] target_q;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_next, wait_inc;

    logic [2:0]          cur_op;
    logic [PC_WIDTH-1:0] off_ext;
    logic [PC_WIDTH-1:0] new_target;
    logic [PC_WIDTH-1:0] cur_target;
    logic                rs_need, rt_need, ready, active, fire, cond, timeout_set;
    logic                rs_neg, rs_zero;

    // Operand readiness, branch condition and FSM next state
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        timeout_set   = 1'b0;

        cur_op     = (state == ST_WAIT) ? op_q : branchOp;
        off_ext    = PC_WIDTH'($signed(offsetInput));
        new_target = pcPlus4Input + (off_ext << 2);
        cur_target = (state == ST_WAIT) ? target_q : new_target;

        rs_need = (cur_op <= OP_BGEZ);
        rt_need = (cur_op <= OP_BNE);
        ready   = (!rs_need || rsReady) && (!rt_need || rtReady);
        active  = (state == ST_WAIT) || branchValid;
        fire    = active && ready && !flush;

        rs_neg  = dataRsInput[DATA_WIDTH-1];
        rs_zero = (dataRsInput == '0);
        case (cur_op)
            OP_BEQ:  cond = (dataRsInput == dataRtInput);
            OP_BNE:  cond = (dataRsInput != dataRtInput);
            OP_BLEZ: cond = rs_neg || rs_zero;
            OP_BGTZ: cond = !rs_neg && !rs_zero;
            OP_BLTZ: cond = rs_neg;
            OP_BGEZ: cond = !rs_neg;
            default: cond = 1'b0;
        endcase

        stallOutput = !reset && !flush && active && !ready;

        wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + WAIT_W'(1);

        if (flush) begin
            state_next    = ST_IDLE;
            wait_cnt_next = '0;
        end else if (state == ST_IDLE) begin
            if (branchValid && !ready) begin
                state_next    = ST_WAIT;
                wait_cnt_next = WAIT_W'(1);
            end
        end else begin
            if (ready) begin
                state_next    = ST_IDLE;
                wait_cnt_next = '0;
            end else begin
                wait_cnt_next = wait_inc;
                timeout_set   = (wait_inc > WAIT_W'(MAX_WAIT));
            end
        end
    end

    // State, latched branch context and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            op_q          <= '0;
            target_q      <= '0;
            resolvedValid <= 1'b0;
            takenOutput   <= 1'b0;
            targetOutput  <= '0;
            timeoutError  <= 1'b0;
            stallCycles   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state == ST_IDLE && branchValid && !flush) begin
                op_q     <= branchOp;
                target_q <= new_target;
            end
            resolvedValid <= fire;
            if (fire) begin
                takenOutput  <= cond;
                targetOutput <= cur_target;
            end
            if (timeout_set) begin
                timeoutError <= 1'b1;
            end
            if (stallOutput && stallCycles != '1) begin
                stallCycles <= stallCycles + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: operand waits, conditions, target wrap,
// timeout, flush and asynchronous reset.
module tb_branch_resolve_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        branchValid;
    logic [2:0]  branchOp;
    logic [31:0] dataRsInput;
    logic [31:0] dataRtInput;
    logic        rsReady;
    logic        rtReady;
    logic [31:0] pcPlus4Input;
    logic [15:0] offsetInput;
    logic        flush;
    logic        stallOutput;
    logic        resolvedValid;
    logic        takenOutput;
    logic [31:0] targetOutput;
    logic        timeoutError;
    logic [15:0] stallCycles;

    int n_cmp = 0;
    int n_err = 0;

    branch_resolve_unit dut (
        .clock        (clock),
        .reset        (reset),
        .branchValid  (branchValid),
        .branchOp     (branchOp),
        .dataRsInput  (dataRsInput),
        .dataRtInput  (dataRtInput),
        .rsReady      (rsReady),
        .rtReady      (rtReady),
        .pcPlus4Input (pcPlus4Input),
        .offsetInput  (offsetInput),
        .flush        (flush),
        .stallOutput  (stallOutput),
        .resolvedValid(resolvedValid),
        .takenOutput  (takenOutput),
        .targetOutput (targetOutput),
        .timeoutError (timeoutError),
        .stallCycles  (stallCycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic rsr, input logic rtr, input logic [31:0] pc,
                         input logic [15:0] off);
        @(negedge clock);
        branchValid  = 1'b1;
        branchOp     = op;
        dataRsInput  = rs;
        dataRtInput  = rt;
        rsReady      = rsr;
        rtReady      = rtr;
        pcPlus4Input = pc;
        offsetInput  = off;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [2:0]  tab_op [4];
    logic [31:0] tab_rs [4];
    logic        tab_tk [4];

    initial begin
        reset = 1'b1; branchValid = 1'b0; branchOp = 3'b000; dataRsInput = '0; dataRtInput = '0;
        rsReady = 1'b0; rtReady = 1'b0; pcPlus4Input = '0; offsetInput = '0; flush = 1'b0;
        #12;
        check("rst_valid", 32'(resolvedValid), 32'd0);
        check("rst_taken", 32'(takenOutput), 32'd0);
        check("rst_target", targetOutput, 32'd0);
        check("rst_timeout", 32'(timeoutError), 32'd0);
        check("rst_stallcnt", 32'(stallCycles), 32'd0);
        check("rst_stall", 32'(stallOutput), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // BEQ with both operands ready: latency 1, no stall
        drive(3'b000, 32'h0000_00A5, 32'h0000_00A5, 1'b1, 1'b1, 32'h0040_0010, 16'h0004);
        check("beq_stall", 32'(stallOutput), 32'd0);
        step();
        branchValid = 1'b0;
        check("beq_valid", 32'(resolvedValid), 32'd1);
        check("beq_taken", 32'(takenOutput), 32'd1);
        check("beq_target", targetOutput, 32'h0040_0020);
        step();
        check("beq_pulse_end", 32'(resolvedValid), 32'd0);
        check("beq_hold_target", targetOutput, 32'h0040_0020);

        // Single-operand branches issued back-to-back with rt never ready
        tab_op[0] = 3'b011; tab_rs[0] = 32'h8000_0000; tab_tk[0] = 1'b0;
        tab_op[1] = 3'b010; tab_rs[1] = 32'h0000_0000; tab_tk[1] = 1'b1;
        tab_op[2] = 3'b100; tab_rs[2] = 32'hFFFF_FFFF; tab_tk[2] = 1'b1;
        tab_op[3] = 3'b101; tab_rs[3] = 32'h0000_0000; tab_tk[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(tab_op[i], tab_rs[i], 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0100, 16'h0000);
            check("rs_only_stall", 32'(stallOutput), 32'd0);
            step();
            check("rs_only_valid", 32'(resolvedValid), 32'd1);
            check("rs_only_taken", 32'(takenOutput), 32'(tab_tk[i]));
            check("rs_only_target", targetOutput, 32'h0000_0100);
        end
        branchValid = 1'b0;
        check("rs_only_stallcnt", 32'(stallCycles), 32'd0);

        // BNE waiting three cycles on rt
        drive(3'b001, 32'd1, 32'd2, 1'b1, 1'b0, 32'h0000_1000, 16'h0010);
        check("bne_stall0", 32'(stallOutput), 32'd1);
        step();
        branchValid = 1'b0;
        branchOp = 3'b000;
        pcPlus4Input = 32'hDEAD_BEEC;
        for (int i = 1; i < 3; i++) begin
            @(negedge clock); #1;
            check("bne_stall_wait", 32'(stallOutput), 32'd1);
            check("bne_no_valid", 32'(resolvedValid), 32'd0);
            step();
        end
        @(negedge clock);
        rtReady = 1'b1;
        #1;
        check("bne_stall_eval", 32'(stallOutput), 32'd0);
        step();
        check("bne_valid", 32'(resolvedValid), 32'd1);
        check("bne_taken", 32'(takenOutput), 32'd1);
        check("bne_target", targetOutput, 32'h0000_1040);
        check("bne_stallcnt", 32'(stallCycles), 32'd3);

        // Target wrap and reserved op
        drive(3'b000, 32'd9, 32'd9, 1'b1, 1'b1, 32'h0000_0000, 16'hFFFF);
        step();
        check("wrap_target", targetOutput, 32'hFFFF_FFFC);
        check("wrap_taken", 32'(takenOutput), 32'd1);
        drive(3'b111, 32'd9, 32'd9, 1'b0, 1'b0, 32'h0000_0020, 16'h0001);
        check("rsvd_stall", 32'(stallOutput), 32'd0);
        step();
        branchValid = 1'b0;
        check("rsvd_valid", 32'(resolvedValid), 32'd1);
        check("rsvd_taken", 32'(takenOutput), 32'd0);
        check("rsvd_target", targetOutput, 32'h0000_0024);

        // BGEZ with rs not ready for 9 cycles: timeout raised after the 8th clock
        drive(3'b101, 32'd5, 32'd0, 1'b0, 1'b0, 32'h0000_0200, 16'h0002);
        check("to_stall0", 32'(stallOutput), 32'd1);
        step();
        branchValid = 1'b0;
        for (int i = 2; i <= 7; i++) begin
            @(negedge clock); #1;
            check("to_stall_wait", 32'(stallOutput), 32'd1);
            step();
        end
        check("to_not_yet", 32'(timeoutError), 32'd0);
        @(negedge clock);
        step();
        check("to_set", 32'(timeoutError), 32'd1);
        @(negedge clock);
        step();
        @(negedge clock);
        rsReady = 1'b1;
        #1;
        check("to_stall_eval", 32'(stallOutput), 32'd0);
        step();
        check("to_valid", 32'(resolvedValid), 32'd1);
        check("to_taken", 32'(takenOutput), 32'd1);
        check("to_target", targetOutput, 32'h0000_0208);
        check("to_sticky", 32'(timeoutError), 32'd1);
        check("to_stallcnt", 32'(stallCycles), 32'd12);

        // Flush while waiting suppresses the resolution
        drive(3'b000, 32'd3, 32'd3, 1'b0, 1'b1, 32'h0000_0300, 16'h0000);
        check("fl_stall0", 32'(stallOutput), 32'd1);
        step();
        branchValid = 1'b0;
        @(negedge clock);
        flush = 1'b1;
        rsReady = 1'b1;
        #1;
        check("fl_stall", 32'(stallOutput), 32'd0);
        step();
        check("fl_no_valid", 32'(resolvedValid), 32'd0);
        @(negedge clock);
        flush = 1'b0;
        #1;
        check("fl_idle_stall", 32'(stallOutput), 32'd0);
        step();
        check("fl_no_valid2", 32'(resolvedValid), 32'd0);
        check("fl_stallcnt", 32'(stallCycles), 32'd13);
        check("fl_hold_taken", 32'(takenOutput), 32'd1);
        check("fl_hold_target", targetOutput, 32'h0000_0208);

        // Asynchronous reset while waiting
        drive(3'b000, 32'd7, 32'd7, 1'b0, 1'b0, 32'h0000_0040, 16'hFFFE);
        check("ar_stall0", 32'(stallOutput), 32'd1);
        step();
        branchValid = 1'b0;
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("ar_stall", 32'(stallOutput), 32'd0);
        check("ar_valid", 32'(resolvedValid), 32'd0);
        check("ar_taken", 32'(takenOutput), 32'd0);
        check("ar_target", targetOutput, 32'd0);
        check("ar_timeout", 32'(timeoutError), 32'd0);
        check("ar_stallcnt", 32'(stallCycles), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        drive(3'b000, 32'd7, 32'd7, 1'b1, 1'b1, 32'h0000_0040, 16'hFFFE);
        check("post_stall", 32'(stallOutput), 32'd0);
        step();
        branchValid = 1'b0;
        check("post_valid", 32'(resolvedValid), 32'd1);
        check("post_taken", 32'(takenOutput), 32'd1);
        check("post_target", targetOutput, 32'h0000_0038);
        step();
        check("post_pulse_end", 32'(resolvedValid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
